// File: rtl/mac_seq.sv
// mac_seq: operand sequencer feeding the 8-bit MAC stage.
// Streams W*x one row at a time: HOLD_CYC cycles with mac_en high, then
// GAP_CYC cycles low so the MAC clears its accumulator before the next row.
// Optional build macro: MAC_SEQ_CONT_EN (adds the cont input for back-to-back
// frames; when undefined every frame returns to IDLE).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; host writes to W/x are accepted
// RUN   | mac_en high, k walks 0..HOLD_CYC-1, operands valid for k<VEC_LEN
// GAP   | mac_en low for GAP_CYC cycles, addr holds the finished row
// DONE  | one-cycle done pulse, then IDLE (or RUN again when cont latched)
module mac_seq #(
  parameter int DATA_W   = 8,
  parameter int VEC_LEN  = 8,
  parameter int HOLD_CYC = 10,
  parameter int GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MAC_SEQ_CONT_EN
  input  logic              cont,
`endif
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              mac_en,
  output logic [2:0]        addr
);

  // k must be able to reach HOLD_CYC so the RUN increment never wraps early
  localparam int KW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [KW-1:0] K_LAST   = KW'(HOLD_CYC - 1);
  localparam logic [KW-1:0] K_VEC    = KW'(VEC_LEN);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [2:0]    ROW_LAST = 3'(VEC_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [KW-1:0]     k_q, k_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              cont_q, cont_d;
  logic              cont_in;

  logic              busy_d, done_d, mac_en_d;
  logic [DATA_W-1:0] a_d, b_d;
  logic [2:0]        addr_d;

  logic [DATA_W-1:0] w_mem [64];
  logic [DATA_W-1:0] x_mem [8];

`ifdef MAC_SEQ_CONT_EN
  assign cont_in = cont;
`else
  assign cont_in = 1'b0;
`endif

  // Host write port; storage is deliberately not reset, writes only land in IDLE
  always_ff @(posedge clk) begin
    if (wr_en && rst && (state_q == S_IDLE)) begin
      if (wr_sel) x_mem[wr_addr[2:0]] <= wr_data;
      else        w_mem[wr_addr]      <= wr_data;
    end
  end

  // State and sequencing counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      cont_q  <= cont_d;
    end
  end

  // Next-state and counter update; the gap timer is a down-counter ending at zero
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    gap_d   = gap_q;
    cont_d  = cont_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
            cont_d  = cont_in;
          end else begin
            state_d = S_RUN;
            row_d   = row_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE: begin
        cont_d = 1'b0;
        if (cont_q) begin
          state_d = S_RUN;
          row_d   = '0;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state; registered below, so outputs lag state by one cycle
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    mac_en_d = 1'b0;
    a_d      = '0;
    b_d      = '0;
    addr_d   = '0;
    case (state_q)
      S_RUN: begin
        busy_d   = 1'b1;
        mac_en_d = 1'b1;
        addr_d   = row_q;
        if (k_q < K_VEC) begin
          a_d = w_mem[{row_q, k_q[2:0]}];
          b_d = x_mem[k_q[2:0]];
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        addr_d = row_q;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
        addr_d = row_q;
      end
      default: ;
    endcase
  end

  // Output registers; async reset forces mac_en low at once so the MAC clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      mac_en <= 1'b0;
      a      <= '0;
      b      <= '0;
      addr   <= '0;
    end else begin
      busy   <= busy_d;
      done   <= done_d;
      mac_en <= mac_en_d;
      a      <= a_d;
      b      <= b_d;
      addr   <= addr_d;
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: expected per-cycle outputs are queued with a cycle
// stamp when stimulus is driven and compared by a monitor on the falling edge.
module tb_mac_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel, start;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, mac_en;
  logic [7:0] a, b;
  logic [2:0] addr;
`ifdef MAC_SEQ_CONT_EN
  logic       cont = 1'b0;
`endif

  mac_seq dut (
    .clk     (clk),
    .rst     (rst),
`ifdef MAC_SEQ_CONT_EN
    .cont    (cont),
`endif
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a       (a),
    .b       (b),
    .mac_en  (mac_en),
    .addr    (addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mac_en;
    logic [2:0] addr;
    logic [7:0] a;
    logic [7:0] b;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    obs_t        o;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_cnt = 0;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  tw [8][8];
  logic [7:0]  tx [8];
  exp_t        e_cur;
  obs_t        got;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
      e_cur = q.pop_front();
      got   = {busy, done, mac_en, addr, a, b};
      n_total = n_total + 1;
      assert (got === e_cur.o) n_pass = n_pass + 1;
      else $error("FAIL sb cyc=%0d got busy=%b done=%b en=%b addr=%0d a=%h b=%h exp busy=%b done=%b en=%b addr=%0d a=%h b=%h",
                  cyc_cnt, got.busy, got.done, got.mac_en, got.addr, got.a, got.b,
                  e_cur.o.busy, e_cur.o.done, e_cur.o.mac_en, e_cur.o.addr, e_cur.o.a, e_cur.o.b);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic obs_t mk(bit bz, bit dn, bit me, logic [2:0] ad, logic [7:0] aa, logic [7:0] bb);
    obs_t o;
    o.busy = bz; o.done = dn; o.mac_en = me; o.addr = ad; o.a = aa; o.b = bb;
    return o;
  endfunction

  task automatic push(input int unsigned cyc, input obs_t o);
    exp_t e;
    e.cyc = cyc;
    e.o   = o;
    q.push_back(e);
  endtask

  // One frame: 8 rows of 10 RUN + 2 GAP cycles, then the DONE cycle (97 entries)
  task automatic push_frame(input int unsigned base, input bit with_idle);
    int unsigned t = base;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 10; k++) begin
        if (k < 8) push(t, mk(1, 0, 1, 3'(r), tw[r][k], tx[k]));
        else       push(t, mk(1, 0, 1, 3'(r), 8'h00, 8'h00));
        t++;
      end
      for (int g = 0; g < 2; g++) begin
        push(t, mk(1, 0, 0, 3'(r), 8'h00, 8'h00));
        t++;
      end
    end
    push(t, mk(1, 1, 0, 3'd7, 8'h00, 8'h00));
    t++;
    if (with_idle) push(t, mk(0, 0, 0, 3'd0, 8'h00, 8'h00));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total = n_total + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
  endtask

  task automatic wr(input bit sel, input logic [5:0] ad, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = ad; wr_data = d;
    if (sel) tx[ad[2:0]] = d;
    else     tw[ad[5:3]][ad[2:0]] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() > 0 && w < 300) begin
      step();
      w++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic start_frame();
    start = 1'b1;
    push_frame(cyc_cnt + 2, 1'b1);
    step();
    start = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    // Reset held with start and a write request active: nothing may move
    rst = 1'b0; start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'hAA;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_addr", addr, 0);
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    step();
    step();
    chk("post_rst_busy", busy, 0);

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        wr(1'b0, 6'(r * 8 + c), 8'(r * 8 + c));
    for (int k = 0; k < 8; k++)
      wr(1'b1, 6'(k), 8'(k + 1));

    // Frame 1: latency and frame length (first mac_en cycle counted as 1)
    start_frame();
    w = 0;
    while (mac_en !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    chk("rise_latency", w, 1);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("frame_len", n, 97);
    drain();

    // Frame 2: write and start while busy are ignored
    start_frame();
    repeat (20) step();
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 8'hFF; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    drain();

    // Frame 3: still sees the old W[0][0]
    start_frame();
    drain();

    // Frame 4: write x[0] in the same cycle as start
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd0; wr_data = 8'h7F;
    tx[0] = 8'h7F;
    start_frame();
    wr_en = 1'b0;
    drain();

    // Frame 5: reset in the middle of row 4
    start_frame();
    w = 0;
    while (!(mac_en === 1'b1 && addr === 3'd4) && w < 200) begin
      step();
      w++;
    end
    chk("row4_reached", w < 200, 1);
    step();
    step();
    rst = 1'b0;
    #1;
    q.delete();
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_a", a, 0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_idle", busy, 0);
    start_frame();
    drain();

`ifdef MAC_SEQ_CONT_EN
    // Continuous frames: done every 97 cycles, busy never drops, row wraps 7->0
    cont = 1'b1;
    start = 1'b1;
    push_frame(cyc_cnt + 2, 1'b0);
    push_frame(cyc_cnt + 2 + 97, 1'b1);
    step();
    start = 1'b0;
    repeat (120) step();
    cont = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Operand sequencer that sits directly upstream of the 8-bit MAC stage.
- Holds an 8x8 weight matrix W and an 8-entry vector x, both loaded by the host through a simple write port.
- On start, computes W·x one row at a time. For each row it drives the MAC's a/b/mac_en/addr inputs, then holds mac_en low for a gap so the MAC clears its accumulator before the next row.

Parameters:
- DATA_W, 8, operand width of W, x, a and b.
- VEC_LEN, 8, dot-product length and row count; fixed at 8 by the 3-bit addr.
- HOLD_CYC, 10, cycles mac_en is held high per row; must be >= VEC_LEN.
- GAP_CYC, 2, cycles mac_en is held low between rows; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- wr_en  input  1  host write strobe.
- wr_sel  input  1  0 = write W, 1 = write x.
- wr_addr  input  6  W: {row[5:3], col[2:0]}; x: index in [2:0], bits [5:3] ignored.
- wr_data  input  DATA_W  write data.
- start  input  1  single-cycle start request.
- busy  output  1  high from RUN entry until DONE exit.
- done  output  1  one-cycle pulse when the last row's gap ends.
- a  output  DATA_W  MAC operand a.
- b  output  DATA_W  MAC operand b.
- mac_en  output  1  MAC enable.
- addr  output  3  row index, forwarded to the MAC addr input.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; row=0, k=0, gap count=0.
  - All outputs 0.
  - W and x contents are not reset.
- All outputs are registered.
- Storage:
  - W and x are register arrays written on clk when wr_en=1 and state=IDLE.
  - Writes in any other state are ignored.
- FSM:
  - IDLE: start=1 -> RUN with row=0, k=0. start in any other state is ignored.
  - RUN, each cycle:
    - mac_en=1, addr=row.
    - If k<VEC_LEN: a=W[row][k], b=x[k]. Otherwise a=0, b=0.
    - k increments each cycle. When k==HOLD_CYC-1 -> GAP.
  - GAP:
    - mac_en=0, a=0, b=0, addr holds row.
    - After GAP_CYC cycles: if row==7 -> DONE; otherwise row+1, k=0 -> RUN.
  - DONE: one cycle, done=1, busy=1, mac_en=0 -> IDLE.
- Latency:
  - start sampled at edge N gives mac_en=1, a=W[0][0] after edge N+1.
  - A full frame is 8*(HOLD_CYC+GAP_CYC)+1 cycles from the first RUN cycle to the done pulse: 97 cycles with defaults.
- Boundary conditions:
  - start and wr_en in the same IDLE cycle: the write commits and the sequence starts; the new value is visible because the first read happens a cycle later.
  - Reset mid-frame: immediate return to IDLE with mac_en=0. This also clears the MAC's count and accumulator on its next clock.
  - Operands are unsigned bit patterns passed through unchanged; no arithmetic is done here.

Optional Feature:
- Macro: MAC_SEQ_CONT_EN.
- Defined:
  - Adds input cont (1 bit).
  - If cont=1 when the last row's gap ends: done still pulses for one cycle (busy stays 1), and the state goes straight to RUN with row=0. Frames repeat with no extra idle cycles.
  - cont=0 behaves as the base design.
- Undefined:
  - No cont port; every frame ends in IDLE.

Test Plan:
- Reset: hold rst=0 with start=1 and wr_en=1 -> busy=0, done=0, mac_en=0, a=b=0, addr=0. No state change until rst=1.
- Single frame:
  - Stimulus: W[r][c]=r*8+c, x[k]=k+1, pulse start.
  - Row 2 response: a sequence 16..23 with b sequence 1..8, then two cycles of a=b=0 with mac_en=1, then two cycles of mac_en=0; addr=2 throughout.
  - done pulses 97 cycles after the first mac_en rise.
- Ignored inputs while busy: write W[0][0]=0xFF mid-frame and pulse start again.
  - The frame is unchanged.
  - A second frame run after done still reads the old W[0][0].
- Same-cycle write/start: wr_sel=1, wr_addr=0, wr_data=0x7F together with start -> first b output = 0x7F.
- Reset mid-frame: assert rst during row 4 RUN -> mac_en=0 immediately. A later start begins at row=0, k=0.
- MAC_SEQ_CONT_EN with cont=1 -> done pulses every 97 cycles, busy stays 1, and addr wraps 7->0 with the expected gap.
